// File: rtl/prio_event_encoder.sv
// Latches N event strobes into a pending set and issues them one at a time as
// binary indices over a valid/ready output, in fixed-priority or round-robin order.
module prio_event_encoder #(
    parameter int unsigned N           = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] base;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [N-1:0]     scan;
    logic [IDX_W-1:0] offset;
    logic             found;
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;

    logic             load;
    logic [N-1:0]     load_mask;
    logic [N-1:0]     pending_next;
    logic             out_valid_next;
    logic [IDX_W-1:0] out_idx_next;
    logic [IDX_W-1:0] ptr_next;
    logic             overflow_next;
    logic             busy_next;

    // Rotate pending so the search origin sits at bit 0, then take the lowest set bit.
    always_comb begin
        base      = (ROUND_ROBIN != 0) ? ptr : '0;
        dbl       = {pending, pending};
        rot       = N'(dbl >> base);
        scan      = '0;
        offset    = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            scan = rot >> k;
            if (!found && scan[0]) begin
                found  = 1'b1;
                offset = IDX_W'(k);
            end
        end
        sum = SUM_W'(base) + SUM_W'(offset);
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        sel_idx   = IDX_W'(sum);
        sel_valid = |pending;
    end

    // Output slot refill, pending bookkeeping and pointer advance.
    always_comb begin
        load           = !out_valid || out_ready;
        load_mask      = '0;
        out_valid_next = out_valid;
        out_idx_next   = out_idx;
        ptr_next       = ptr;
        if (load) begin
            out_valid_next = sel_valid;
            if (sel_valid) begin
                load_mask    = N'(1) << sel_idx;
                out_idx_next = sel_idx;
                ptr_next     = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
            end
        end
        pending_next  = (pending & ~load_mask) | req_in;
        overflow_next = |(req_in & pending & ~load_mask);
        busy_next     = (|pending_next) || out_valid_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
        end else begin
            pending   <= pending_next;
            out_valid <= out_valid_next;
            out_idx   <= out_idx_next;
            overflow  <= overflow_next;
            busy      <= busy_next;
            ptr       <= ptr_next;
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Scoreboard bench: three encoder configurations share one stimulus stream and
// are compared against an array-based reference model every cycle.
module tb_prio_event_encoder;

    typedef struct packed {
        logic [7:0] pend;
        logic       valid;
        logic [2:0] idx;
        logic       ovf;
        logic       busy;
    } status_t;

    bit         clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;

    logic [2:0] idx0, idx1, idx2;
    logic       v0, v1, v2, o0, o1, o2, b0, b1, b2;
    logic [7:0] p0, p1;
    logic [4:0] p2;

    logic [7:0] d_pend[3];
    logic       d_valid[3];
    logic [2:0] d_idx[3];
    logic       d_ovf[3];
    logic       d_busy[3];

    int cfg_n[3]  = '{8, 8, 5};
    int cfg_rr[3] = '{0, 1, 1};

    logic [7:0] mp[3];
    bit         mvalid[3];
    int         midx[3];
    int         mptr[3];

    status_t sq[3][$];
    int      iq[3][$];
    int      ilog[3][$];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    prio_event_encoder #(.N(8), .IDX_W(3), .ROUND_ROBIN(0)) u_fix (
        .clk(clk), .rst(rst), .req_in(req), .out_idx(idx0), .out_valid(v0),
        .out_ready(ready), .pending(p0), .overflow(o0), .busy(b0));

    prio_event_encoder #(.N(8), .IDX_W(3), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst), .req_in(req), .out_idx(idx1), .out_valid(v1),
        .out_ready(ready), .pending(p1), .overflow(o1), .busy(b1));

    prio_event_encoder #(.N(5), .IDX_W(3), .ROUND_ROBIN(1)) u_n5 (
        .clk(clk), .rst(rst), .req_in(req[4:0]), .out_idx(idx2), .out_valid(v2),
        .out_ready(ready), .pending(p2), .overflow(o2), .busy(b2));

    always_comb begin
        d_pend[0] = p0;  d_pend[1] = p1;  d_pend[2] = {3'b000, p2};
        d_valid[0] = v0; d_valid[1] = v1; d_valid[2] = v2;
        d_idx[0] = idx0; d_idx[1] = idx1; d_idx[2] = idx2;
        d_ovf[0] = o0;   d_ovf[1] = o1;   d_ovf[2] = o2;
        d_busy[0] = b0;  d_busy[1] = b1;  d_busy[2] = b2;
    end

    // A stalled output must keep its index and valid until accepted.
    a_hold0: assert property (@(posedge clk) disable iff (rst)
        (v0 && !ready) |=> (v0 && $stable(idx0))) else $error("FAIL out_hold u_fix");
    a_hold1: assert property (@(posedge clk) disable iff (rst)
        (v1 && !ready) |=> (v1 && $stable(idx1))) else $error("FAIL out_hold u_rr");
    a_hold2: assert property (@(posedge clk) disable iff (rst)
        (v2 && !ready) |=> (v2 && $stable(idx2))) else $error("FAIL out_hold u_n5");

    task automatic chk(string name, int c, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s cfg%0d: got %0h, expected %0h at %0t", name, c, act, exp, $time);
        end
    endtask

    // Reference model: advance each configuration by one clock edge.
    task automatic model_step(bit r, logic [7:0] rq, bit rdy);
        for (int c = 0; c < 3; c++) begin
            int n, start, s, taken, j;
            bit found, load, ovf, anyp;
            status_t st;
            n = cfg_n[c];
            if (!r && mvalid[c] && rdy) iq[c].push_back(midx[c]);
            ovf = 0;
            if (r) begin
                mp[c] = '0; mvalid[c] = 0; midx[c] = 0; mptr[c] = 0;
            end else begin
                load  = !mvalid[c] || rdy;
                found = 0; s = 0;
                start = (cfg_rr[c] != 0) ? mptr[c] : 0;
                for (int i = 0; i < n; i++) begin
                    j = (start + i) % n;
                    if (!found && mp[c][3'(j)]) begin found = 1; s = j; end
                end
                taken = -1;
                if (load) begin
                    mvalid[c] = found;
                    if (found) begin
                        midx[c] = s; taken = s; mptr[c] = (s + 1) % n;
                    end
                end
                for (int k = 0; k < n; k++)
                    if (rq[3'(k)] && mp[c][3'(k)] && k != taken) ovf = 1;
                for (int k = 0; k < n; k++) begin
                    if (k == taken) mp[c][3'(k)] = 1'b0;
                    if (rq[3'(k)]) mp[c][3'(k)] = 1'b1;
                end
            end
            anyp     = |mp[c];
            st.pend  = mp[c];
            st.valid = mvalid[c];
            st.idx   = 3'(midx[c]);
            st.ovf   = ovf;
            st.busy  = anyp || mvalid[c];
            sq[c].push_back(st);
        end
    endtask

    // Monitor: compare every cycle's state and every accepted index.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            status_t s;
            if (sq[c].size() == 0) begin
                checks++; fails++;
                $display("FAIL status_underflow cfg%0d: got empty queue, expected entry", c);
            end else begin
                s = sq[c].pop_front();
                chk("pending",   c, 32'(d_pend[c]),  int'(s.pend));
                chk("out_valid", c, 32'(d_valid[c]), int'(s.valid));
                chk("out_idx",   c, 32'(d_idx[c]),   int'(s.idx));
                chk("overflow",  c, 32'(d_ovf[c]),   int'(s.ovf));
                chk("busy",      c, 32'(d_busy[c]),  int'(s.busy));
            end
            if (d_valid[c] && ready && !rst) begin
                if (iq[c].size() == 0) begin
                    checks++; fails++;
                    $display("FAIL issue_unexpected cfg%0d: got idx %0d, expected none", c, d_idx[c]);
                end else begin
                    chk("issue_idx", c, 32'(d_idx[c]), iq[c].pop_front());
                end
                ilog[c].push_back(int'(d_idx[c]));
            end
        end
    end

    task automatic step(bit r, logic [7:0] rq, bit rdy);
        rst = r; req = rq; ready = rdy;
        model_step(r, rq, rdy);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) step(1'b0, 8'h00, rdy);
    endtask

    task automatic check_log(string name, int c, int exp[$]);
        chk({name, "_count"}, c, 32'(ilog[c].size()), exp.size());
        for (int i = 0; i < exp.size() && i < ilog[c].size(); i++)
            chk(name, c, 32'(ilog[c][i]), exp[i]);
    endtask

    task automatic check_reset_state();
        for (int c = 0; c < 3; c++) begin
            chk("rst_valid",   c, 32'(d_valid[c]), 0);
            chk("rst_pending", c, 32'(d_pend[c]),  0);
            chk("rst_idx",     c, 32'(d_idx[c]),   0);
            chk("rst_ovf",     c, 32'(d_ovf[c]),   0);
            chk("rst_busy",    c, 32'(d_busy[c]),  0);
        end
    endtask

    initial begin
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check_reset_state();

        // Single event
        ilog[0].delete();
        step(1'b0, 8'h20, 1'b1); idle(4, 1'b1);
        check_log("single", 0, '{5});

        // Fixed-priority burst
        ilog[0].delete();
        step(1'b0, 8'hA5, 1'b1); idle(6, 1'b1);
        check_log("burst", 0, '{0, 2, 5, 7});

        // Round-robin ordering from the pointer
        ilog[1].delete();
        step(1'b0, 8'h04, 1'b1); idle(3, 1'b1);
        step(1'b0, 8'h0D, 1'b1); idle(5, 1'b1);
        check_log("rr_order", 1, '{2, 3, 0, 2});

        // Backpressure with merged re-requests
        ilog[0].delete();
        step(1'b0, 8'h02, 1'b0); idle(2, 1'b0);
        step(1'b0, 8'h10, 1'b0); idle(1, 1'b0);
        step(1'b0, 8'h10, 1'b0); idle(3, 1'b0);
        idle(6, 1'b1);
        check_log("merge", 0, '{1, 4});

        // Request on the bit being loaded is a fresh event
        ilog[0].delete();
        step(1'b0, 8'h08, 1'b1); step(1'b0, 8'h08, 1'b1); idle(5, 1'b1);
        check_log("reload", 0, '{3, 3});

        // Reset with everything pending and a held output
        step(1'b0, 8'hFF, 1'b0); idle(2, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check_reset_state();
        ilog[0].delete();
        step(1'b0, 8'h80, 1'b1); idle(5, 1'b1);
        check_log("after_rst", 0, '{7});

        // All lines at once
        ilog[0].delete(); ilog[2].delete();
        step(1'b0, 8'hFF, 1'b1); idle(10, 1'b1);
        check_log("all_fix", 0, '{0, 1, 2, 3, 4, 5, 6, 7});
        check_log("all_n5", 2, '{0, 1, 2, 3, 4});

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            bit r, rdy;
            int sel;
            logic [7:0] rq;
            r   = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 3);
            rq  = (sel == 0) ? 8'($urandom) : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rq, rdy);
        end
        idle(20, 1'b1);

        @(negedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("status_drain", c, 32'(sq[c].size()), 0);
            chk("issue_drain",  c, 32'(iq[c].size()), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/prio_event_encoder.md
Name: prio_event_encoder

Overview:
- Parametrised, registered successor to the one-hot encoder: converts N request lines into a stream of binary indices.
- Any number of request bits may be asserted in a cycle. Each request is latched as a pending event.
- Pending events are issued one at a time through a valid/ready output, using either fixed-priority or round-robin order.
- Sits between interrupt/event sources and a single consumer that needs a binary index.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDX_W, 3, width of the index output; must equal ceil(log2(N)).
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last issued index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  event strobes; each asserted bit posts one event for that index.
- out_idx  output  IDX_W  binary index of the issued event.
- out_valid  output  1  out_idx holds an event.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- pending  output  N  registered set of latched, not-yet-issued events.
- overflow  output  1  one-cycle pulse: a request merged into an already-pending bit.
- busy  output  1  |pending || out_valid.

Behaviour:
- Reset (rst high at clock edge):
  - pending = 0, out_valid = 0, out_idx = 0, overflow = 0, round-robin pointer = 0.
  - req_in is ignored on reset cycles.
- load = !out_valid || out_ready (output slot empty or being drained this cycle).
- Selection (combinational, from the pending register only):
  - Fixed mode: lowest set index of pending.
  - RR mode: first set index searching upward from ptr, wrapping N-1 -> 0.
  - sel_valid = |pending.
- Output register on load:
  - out_valid <= sel_valid.
  - If sel_valid: out_idx <= selected index; load_mask = onehot(selected index).
  - Otherwise out_idx holds its value and load_mask = 0.
- Output hold: when !load (out_valid && !out_ready), out_idx and out_valid hold stable. This is mandatory and verified by assertion.
- pending update: pending <= (pending & ~load_mask) | req_in. An issued bit leaves pending in the same edge it enters the output register.
- overflow <= |(req_in & pending & ~load_mask). The request is merged, not queued; the bit stays set.
- A request on the bit being loaded in the same cycle is a new event: it re-sets pending and does not raise overflow.
- RR pointer:
  - On load with sel_valid: ptr <= (selected + 1) mod N.
  - N not a power of two: wraps at N, never at 2^IDX_W.
  - Unchanged otherwise.
- Latency:
  - req_in high in cycle 0 -> pending bit set in cycle 1 -> out_valid in cycle 2 (output slot empty).
  - Back-to-back throughput: one index per cycle while out_ready = 1 and events are pending.
- Boundary conditions:
  - All N bits in one cycle -> N issues over N consecutive cycles (out_ready = 1), no overflow.
  - out_ready high while out_valid = 0 has no effect.
  - Reset mid-transfer drops all pending events and the held output immediately.
- out_idx is never an index >= N.

Test Plan:
- Single event: rst 2 cycles, req_in = 8'b0010_0000 in cycle 0, out_ready = 1 -> out_valid = 1, out_idx = 5 in cycle 2 only; pending = 0 from cycle 2; busy low from cycle 3.
- Fixed priority burst: req_in = 8'hA5 for one cycle, out_ready = 1 -> out_idx sequence 0, 2, 5, 7 on cycles 2-5; overflow never asserted.
- Round-robin (ROUND_ROBIN = 1):
  - Issue index 2 first.
  - Then req_in = 8'b0000_1101 -> order 3, 0, 2 (search starts at ptr = 3).
- Backpressure and merge:
  - Hold out_ready = 0 with out_idx = 1 valid for 5 cycles -> out_idx/out_valid stable.
  - Re-pulse req_in bit 4 twice while bit 4 is pending -> one overflow pulse on the second pulse, a single issue of 4 after release.
- Same-cycle reload: bit 3 loaded into the output while req_in bit 3 pulses -> no overflow; index 3 issued twice.
- Reset mid-operation:
  - pending = 8'hFF and out_valid = 1, assert rst for 1 cycle -> next cycle all outputs 0, ptr = 0.
  - Subsequent req_in = 8'h80 -> out_idx = 7 two cycles later.
- N = 5, IDX_W = 3, RR mode, all requests -> indices 0-4 in order, ptr wraps 4 -> 0; out_idx never 5-7.
